// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and related bus arbiters.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } arb_state_e;

   localparam int DEF_NUM_REQ      = 2;
   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_MAX_BURST    = 64;
   localparam int DEF_IDLE_TIMEOUT = 1024;

   // Index width for n entries, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request after ptr, wrapping modulo N.
module rr_priority_picker
   import uart_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = idx_width(DEF_NUM_REQ)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;
   logic          found;

   // NOTE: every variable assigned here gets a default first, so no path leaves one holding its old value (no latch).
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = ptr;
      for (int i = 0; i < N; i++) begin
         cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX serializer between byte-stream requesters.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          tx_valid_o,
   output logic [DATA_WIDTH-1:0]         tx_data_o,
   input  logic                          tx_ready_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_TIMEOUT);

   arb_state_e           state_q, state_d;
   logic [IW-1:0]        grant_idx_q, grant_idx_d;
   logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]        burst_q, burst_d;
   logic [TW-1:0]        idle_q, idle_d;

   logic [NUM_REQ-1:0]   win_oh;
   logic [IW-1:0]        win_idx;
   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
   logic                 owner_valid, owner_last, xfer;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_bytes[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_picker (
      .req    (req_valid_i),
      .ptr    (rr_ptr_q),
      .onehot (win_oh),
      .idx    (win_idx)
   );

   assign owner_valid = |(req_valid_i & grant_oh_q);
   assign owner_last  = |(req_last_i & grant_oh_q);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         rr_ptr_q    <= IW'(NUM_REQ - 1);
         burst_q     <= '0;
         idle_q      <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         grant_oh_q  <= grant_oh_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_q     <= burst_d;
         idle_q      <= idle_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      grant_oh_d  = grant_oh_q;
      rr_ptr_d    = rr_ptr_q;
      burst_d     = burst_q;
      idle_d      = idle_q;
      req_ready_o = '0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      grant_o     = '0;
      busy_o      = 1'b0;
      xfer        = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               state_d     = GRANT;
               grant_idx_d = win_idx;
               grant_oh_d  = win_oh;
               burst_d     = '0;
               idle_d      = '0;
            end
         end

         GRANT: begin
            grant_o     = grant_oh_q;
            busy_o      = 1'b1;
            tx_valid_o  = owner_valid;
            tx_data_o   = owner_valid ? req_bytes[grant_idx_q] : '0;
            req_ready_o = tx_ready_i ? grant_oh_q : '0;
            xfer        = owner_valid && tx_ready_i;

            if (xfer && burst_q != BURST_MAX) burst_d = burst_q + 1'b1;

            // A stalled-but-valid owner keeps the counter clear, so backpressure never times out.
            if (owner_valid)            idle_d = '0;
            else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;

            if ((xfer && (owner_last || burst_d == BURST_MAX)) || idle_d == IDLE_MAX)
               state_d = RELEASE;
         end

         RELEASE: begin
            rr_ptr_d = grant_idx_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (2 requesters, burst 4, idle timeout 8).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        tx_valid, tx_ready, busy;
   logic [7:0]  tx_data;

   int n_cmp = 0;
   int n_err = 0;
   int mon_err = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (2),
      .DATA_WIDTH   (8),
      .MAX_BURST    (4),
      .IDLE_TIMEOUT (8)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .tx_ready_i  (tx_ready),
      .grant_o     (grant),
      .busy_o      (busy)
   );

   // Stimulus protocol monitor: a valid byte not yet accepted must stay valid.
   logic [1:0] prev_valid, prev_ready;
   logic       prev_reset = 1'b1;
   always @(negedge clk) begin
      if (!reset && !prev_reset) begin
         for (int k = 0; k < 2; k++) begin
            if (prev_valid[k] && !prev_ready[k]) begin
               assert (req_valid[k] === 1'b1) else begin
                  mon_err <= mon_err + 1;
                  $error("FAIL valid_stable req%0d observed=%b expected=1", k, req_valid[k]);
               end
            end
         end
      end
      prev_valid <= req_valid;
      prev_ready <= req_ready;
      prev_reset <= reset;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compares {grant, busy, tx_valid, tx_data, req_ready}; busy is expected whenever a grant is shown.
   task automatic exp_out(input string tag, input logic [1:0] g, input logic v,
                          input logic [7:0] d, input logic [1:0] r);
      #1;
      check({tag, " {grant,busy,valid,data,ready}"},
            {18'd0, grant, busy, tx_valid, tx_data, req_ready},
            {18'd0, g, |g, v, d, r});
   endtask

   task automatic idle_chk(input string tag);
      exp_out(tag, 2'b00, 1'b0, 8'h00, 2'b00);
   endtask

   task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] l);
      req_valid = v;
      req_data  = {d1, d0};
      req_last  = l;
   endtask

   initial begin
      reset    = 1'b1;
      tx_ready = 1'b1;
      drive(2'b00, 8'h00, 8'h00, 2'b00);
      cyc();
      cyc();
      idle_chk("reset");
      reset = 1'b0;

      // Single requester, three-byte packet.
      cyc(); drive(2'b01, 8'h41, 8'h00, 2'b00); idle_chk("t1_arb");
      cyc(); exp_out("t1_b0", 2'b01, 1'b1, 8'h41, 2'b01);
      cyc(); drive(2'b01, 8'h42, 8'h00, 2'b00); exp_out("t1_b1", 2'b01, 1'b1, 8'h42, 2'b01);
      cyc(); drive(2'b01, 8'h43, 8'h00, 2'b01); exp_out("t1_b2", 2'b01, 1'b1, 8'h43, 2'b01);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t1_release");
      cyc(); idle_chk("t1_idle");

      // Simultaneous requests straight out of reset: req0 first, then req1.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      drive(2'b11, 8'hA0, 8'hB0, 2'b00); idle_chk("t2_arb");
      cyc(); exp_out("t2_r0b0", 2'b01, 1'b1, 8'hA0, 2'b01);
      cyc(); drive(2'b11, 8'hA1, 8'hB0, 2'b01); exp_out("t2_r0b1", 2'b01, 1'b1, 8'hA1, 2'b01);
      cyc(); drive(2'b10, 8'h00, 8'hB0, 2'b00); idle_chk("t2_rel0");
      cyc(); idle_chk("t2_gap");
      cyc(); exp_out("t2_r1b0", 2'b10, 1'b1, 8'hB0, 2'b10);
      cyc(); drive(2'b10, 8'h00, 8'hB1, 2'b10); exp_out("t2_r1b1", 2'b10, 1'b1, 8'hB1, 2'b10);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t2_rel1");
      cyc(); drive(2'b11, 8'hC0, 8'hD0, 2'b11); idle_chk("t2_rep_arb");
      cyc(); exp_out("t2_rep_r0", 2'b01, 1'b1, 8'hC0, 2'b01);
      cyc(); drive(2'b10, 8'h00, 8'hD0, 2'b10); idle_chk("t2_rep_rel0");
      cyc(); idle_chk("t2_rep_gap");
      cyc(); exp_out("t2_rep_r1", 2'b10, 1'b1, 8'hD0, 2'b10);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t2_rep_rel1");

      // Burst limit of 4 on an unterminated req1 stream.
      cyc(); drive(2'b10, 8'h00, 8'h10, 2'b00); idle_chk("t3_arb");
      cyc(); exp_out("t3_b0", 2'b10, 1'b1, 8'h10, 2'b10);
      for (int i = 1; i < 4; i++) begin
         cyc(); drive(2'b10, 8'h00, 8'(16 + i), 2'b00);
         exp_out($sformatf("t3_b%0d", i), 2'b10, 1'b1, 8'(16 + i), 2'b10);
      end
      cyc(); drive(2'b10, 8'h00, 8'h14, 2'b00); idle_chk("t3_burst_rel");
      cyc(); idle_chk("t3_gap");
      cyc(); exp_out("t3_regain", 2'b10, 1'b1, 8'h14, 2'b10);
      cyc(); drive(2'b11, 8'h55, 8'h15, 2'b01); exp_out("t3_ignore_r0", 2'b10, 1'b1, 8'h15, 2'b10);
      cyc(); drive(2'b11, 8'h55, 8'h16, 2'b01); exp_out("t3_b6", 2'b10, 1'b1, 8'h16, 2'b10);
      cyc(); drive(2'b11, 8'h55, 8'h17, 2'b01); exp_out("t3_b7", 2'b10, 1'b1, 8'h17, 2'b10);
      cyc(); drive(2'b11, 8'h55, 8'h18, 2'b01); idle_chk("t3_burst_rel2");
      cyc(); idle_chk("t3_gap2");
      cyc(); exp_out("t3_r0_next", 2'b01, 1'b1, 8'h55, 2'b01);
      cyc(); drive(2'b10, 8'h00, 8'h18, 2'b00); idle_chk("t3_rel_r0");
      cyc(); idle_chk("t3_gap3");
      cyc(); exp_out("t3_b8", 2'b10, 1'b1, 8'h18, 2'b10);
      cyc(); drive(2'b10, 8'h00, 8'h19, 2'b10); exp_out("t3_b9", 2'b10, 1'b1, 8'h19, 2'b10);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t3_rel_end");

      // Idle timeout: one byte without last, then valid drops for 8 cycles.
      cyc(); drive(2'b01, 8'h61, 8'h00, 2'b00); idle_chk("t4_arb");
      cyc(); exp_out("t4_b0", 2'b01, 1'b1, 8'h61, 2'b01);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) drive(2'b00, 8'h00, 8'h00, 2'b00);
         exp_out($sformatf("t4_wait%0d", k), 2'b01, 1'b0, 8'h00, 2'b01);
      end
      cyc(); idle_chk("t4_timeout_rel");
      cyc(); idle_chk("t4_idle");

      // Backpressure: 100 stalled cycles must not time out.
      cyc(); drive(2'b01, 8'h77, 8'h00, 2'b01); tx_ready = 1'b0; idle_chk("t5_arb");
      cyc(); exp_out("t5_hold", 2'b01, 1'b1, 8'h77, 2'b00);
      for (int i = 0; i < 100; i++) begin
         cyc(); exp_out($sformatf("t5_bp%0d", i), 2'b01, 1'b1, 8'h77, 2'b00);
      end
      cyc(); tx_ready = 1'b1; exp_out("t5_go", 2'b01, 1'b1, 8'h77, 2'b01);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t5_rel");
      cyc(); idle_chk("t5_idle");

      // Reset in the middle of a five-byte packet.
      cyc(); drive(2'b01, 8'h81, 8'h00, 2'b00); idle_chk("t6_arb");
      cyc(); exp_out("t6_b0", 2'b01, 1'b1, 8'h81, 2'b01);
      cyc(); drive(2'b01, 8'h82, 8'h00, 2'b00); exp_out("t6_b1", 2'b01, 1'b1, 8'h82, 2'b01);
      cyc(); drive(2'b01, 8'h83, 8'h00, 2'b00); exp_out("t6_b2", 2'b01, 1'b1, 8'h83, 2'b01);
      #1 reset = 1'b1;
      idle_chk("t6_async_reset");
      cyc(); reset = 1'b0; drive(2'b10, 8'h00, 8'h91, 2'b10); idle_chk("t6_arb_r1");
      cyc(); exp_out("t6_r1_wins", 2'b10, 1'b1, 8'h91, 2'b10);
      cyc(); drive(2'b00, 8'h00, 8'h00, 2'b00); idle_chk("t6_rel");
      reset = 1'b1;
      cyc(); reset = 1'b0; drive(2'b11, 8'hA5, 8'hB5, 2'b00); idle_chk("t6_arb_both");
      cyc(); exp_out("t6_r0_wins", 2'b01, 1'b1, 8'hA5, 2'b01);

      cyc();
      check("valid_stable_violations", 32'(mon_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
